// File: rtl/vga_pkg.sv
// Shared types for the VGA back-end: mode/phase encodings, per-pixel control word, bar LUT.
package vga_pkg;

    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        PASS  = 2'd0,
        BARS  = 2'd1,
        BLANK = 2'd2,
        PASS2 = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_e;

    // Control that travels alongside a pixel while its colour is being fetched.
    typedef struct packed {
        logic       visible;
        logic       hs_act;
        logic       vs_act;
        logic [2:0] bar;
    } ctl_t;

    // Returns {blue, green, red} on/off enables; the caller widens each bit to COLOR_W.
    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        logic [2:0] m;
        case (idx)
            3'd0:    m = 3'b111; // white
            3'd1:    m = 3'b011; // yellow
            3'd2:    m = 3'b110; // cyan
            3'd3:    m = 3'b010; // green
            3'd4:    m = 3'b101; // magenta
            3'd5:    m = 3'b001; // red
            3'd6:    m = 3'b100; // blue
            default: m = 3'b000; // black
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One video axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase tracker.
// Latency: count and phase update on the cycle inc is high; last is combinational.
// Backpressure: none; holds whenever inc is low, or at the last index while wrap_en is low.
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       inc,
    input  logic                       wrap_en,
    output logic [vga_pkg::CNT_W-1:0]  count,
    output vga_pkg::phase_e            phase,
    output logic                       last
);
    localparam int W = vga_pkg::CNT_W;
    localparam logic [W-1:0] ACT_END = W'(ACTIVE - 1);
    localparam logic [W-1:0] FP_END  = W'(ACTIVE + FP - 1);
    localparam logic [W-1:0] SY_END  = W'(ACTIVE + FP + SYNC - 1);
    localparam logic [W-1:0] TOT_END = W'(ACTIVE + FP + SYNC + BP - 1);

    logic step;

    assign last = (count == TOT_END);
    assign step = inc && (!last || wrap_en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            phase <= vga_pkg::ACTIVE;
        end else if (step) begin
            count <= last ? '0 : count + 1'b1;
            case (phase)
                vga_pkg::ACTIVE: if (count == ACT_END) phase <= vga_pkg::FRONT;
                vga_pkg::FRONT:  if (count == FP_END)  phase <= vga_pkg::SYNC;
                vga_pkg::SYNC:   if (count == SY_END)  phase <= vga_pkg::BACK;
                default:         if (last)             phase <= vga_pkg::ACTIVE;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_painter.sv
// VGA back-end: raster timing, upstream pixel requests, colour/sync alignment to DAC pins.
// Latency: PIPE_LAT+1 pix_en cycles from counter value (req_out) to pins.
// Backpressure: none; pix_en low freezes counters, pipeline and outputs.
module vga_timing_painter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int COLOR_W  = 8,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int PIPE_LAT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pix_en,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   color_in,
    output logic                   req_out,
    output logic [CNT_W-1:0]       req_x,
    output logic [CNT_W-1:0]       req_y,
    output logic                   frame_start,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   sync_n,
    output logic                   blank_n
);
    localparam int   H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int   BAR_W   = H_ACTIVE / 8;
    localparam logic HS_ON   = 1'(HS_POL);
    localparam logic VS_ON   = 1'(VS_POL);

    if (H_ACTIVE % 8 != 0) begin : g_bad_hactive
        $error("H_ACTIVE must be divisible by 8");
    end
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_bad_lat
        $error("PIPE_LAT must be in 0..7");
    end

    logic [CNT_W-1:0] h, v;
    phase_e           h_phase, v_phase;
    logic             h_last, unused_v_last;

    vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h_axis (
        .clk     (clk),
        .reset   (reset),
        .inc     (pix_en),
        .wrap_en (1'b1),
        .count   (h),
        .phase   (h_phase),
        .last    (h_last)
    );

    vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v_axis (
        .clk     (clk),
        .reset   (reset),
        .inc     (pix_en & h_last),
        .wrap_en (h_last),
        .count   (v),
        .phase   (v_phase),
        .last    (unused_v_last)
    );

    ctl_t s0;
    always_comb begin
        s0         = '0;
        s0.visible = (h_phase == ACTIVE) && (v_phase == ACTIVE);
        s0.hs_act  = (h_phase == SYNC);
        s0.vs_act  = (v_phase == SYNC);
        for (int i = 1; i < 8; i++) begin
            if (h >= CNT_W'(i * BAR_W)) s0.bar = 3'(i);
        end
    end

    assign req_out     = s0.visible;
    assign req_x       = s0.visible ? h : '0;
    assign req_y       = s0.visible ? v : '0;
    assign frame_start = (h == '0) && (v == '0) && pix_en;

    // Control is delayed to meet the colour returning from upstream.
    ctl_t dly;
    if (PIPE_LAT == 0) begin : g_no_dly
        assign dly = s0;
    end else begin : g_dly
        ctl_t pipe [PIPE_LAT];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
            end else if (pix_en) begin
                pipe[0] <= s0;
                for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign dly = pipe[PIPE_LAT-1];
    end

    mode_e mode_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            mode_q <= PASS;
        else if (frame_start) mode_q <= mode_e'(mode);
    end

    logic [3*COLOR_W-1:0] pix_rgb;
    logic [2:0]           bar_en;
    always_comb begin
        pix_rgb = '0;
        bar_en  = bar_mask(dly.bar);
        if (dly.visible) begin
            case (mode_q)
                BARS:    pix_rgb = {{COLOR_W{bar_en[2]}}, {COLOR_W{bar_en[1]}}, {COLOR_W{bar_en[0]}}};
                BLANK:   pix_rgb = '0;
                default: pix_rgb = color_in;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {blue, green, red} <= '0;
            hsync              <= ~HS_ON;
            vsync              <= ~VS_ON;
            sync_n             <= 1'b1;
            blank_n            <= 1'b0;
        end else if (pix_en) begin
            {blue, green, red} <= pix_rgb;
            hsync              <= dly.hs_act ? HS_ON : ~HS_ON;
            vsync              <= dly.vs_act ? VS_ON : ~VS_ON;
            sync_n             <= ~(dly.hs_act | dly.vs_act);
            blank_n            <= dly.visible && (mode_q != BLANK);
        end
    end

endmodule

// File: tb/tb_vga_timing_painter.sv
// Bench for vga_timing_painter on a shrunken raster: scoreboard of pin values plus vector table.
module tb_vga_timing_painter;
    localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 8,  VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int PL = 2;

    logic        clk = 1'b0;
    logic        reset, pix_en;
    logic [1:0]  mode;
    logic [23:0] color_in;
    logic        req_out, frame_start;
    logic [9:0]  req_x, req_y;
    logic [7:0]  red, green, blue;
    logic        hsync, vsync, sync_n, blank_n;

    always #5 clk = ~clk;

    vga_timing_painter #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .COLOR_W(8), .HS_POL(0), .VS_POL(0), .PIPE_LAT(PL)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .mode(mode), .color_in(color_in),
        .req_out(req_out), .req_x(req_x), .req_y(req_y), .frame_start(frame_start),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .sync_n(sync_n), .blank_n(blank_n)
    );

    typedef struct packed {
        logic [7:0] b, g, r;
        logic hs, vs, sn, bn;
    } pins_t;
    localparam pins_t IDLE = pins_t'({24'h0, 4'b1110});

    typedef struct {
        logic [1:0]  mode;
        int          x;
        int          y;
        logic [23:0] exp_bgr;
    } vec_t;

    int n_cmp, n_bad;
    logic [23:0] bar_bgr [8];
    vec_t vecs [14];

    int         m_h, m_v;
    logic [1:0] m_mode;
    pins_t      sb [$];
    pins_t      last_exp;
    logic       up_vld [PL];
    logic [9:0] up_x [PL], up_y [PL];

    int pe_cnt, fs_last, req_cnt, hs_run, vs_run, hs_fall_last;
    bit fs_valid, hs_fall_valid;
    logic prev_hs, prev_vs;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic pins_t pins_now();
        return {blue, green, red, hsync, vsync, sync_n, blank_n};
    endfunction

    function automatic pins_t model_pins(input int h, input int v, input logic [1:0] md);
        pins_t p;
        logic vis, hs_a, vs_a;
        vis  = (h < HA) && (v < VA);
        hs_a = (h >= HA + HFP) && (h < HA + HFP + HS);
        vs_a = (v >= VA + VFP) && (v < VA + VFP + VS);
        p.hs = ~hs_a;
        p.vs = ~vs_a;
        p.sn = ~(hs_a | vs_a);
        p.bn = vis && (md != 2'd2);
        {p.b, p.g, p.r} = 24'h0;
        if (vis) begin
            case (md)
                2'd1:    {p.b, p.g, p.r} = bar_bgr[h / (HA / 8)];
                2'd2:    {p.b, p.g, p.r} = 24'h0;
                default: {p.b, p.g, p.r} = {8'hFF, 8'(v), 8'(h)};
            endcase
        end
        return p;
    endfunction

    task automatic model_reset();
        m_h = 0; m_v = 0; m_mode = 2'd0;
        sb.delete();
        for (int i = 0; i < PL; i++) begin
            sb.push_back(IDLE);
            up_vld[i] = 1'b0; up_x[i] = '0; up_y[i] = '0;
        end
        last_exp = IDLE;
        fs_valid = 0; hs_fall_valid = 0;
        req_cnt = 0; hs_run = 0; vs_run = 0;
        prev_hs = 1'b1; prev_vs = 1'b1;
    endtask

    // One clock: drive inputs at negedge, check request side, then check pins after posedge.
    task automatic tick(input logic pe);
        pins_t      got;
        logic       exp_req, r_vld;
        logic [9:0] r_x, r_y;
        @(negedge clk);
        pix_en   = pe;
        color_in = up_vld[PL-1] ? {8'hFF, up_y[PL-1][7:0], up_x[PL-1][7:0]} : 24'h5A5A5A;
        #1;
        exp_req = (m_h < HA) && (m_v < VA);
        chk("stage0", {req_out, req_x, req_y, frame_start},
            {exp_req, exp_req ? 10'(m_h) : 10'd0, exp_req ? 10'(m_v) : 10'd0,
             (m_h == 0) && (m_v == 0) && pe});
        r_vld = req_out; r_x = req_x; r_y = req_y;
        if (pe && !reset) begin
            if (frame_start) begin
                if (fs_valid) begin
                    chk("frame_period", pe_cnt - fs_last, FRAME);
                    chk("req_per_frame", req_cnt, HA * VA);
                end
                fs_valid = 1; fs_last = pe_cnt; req_cnt = 0;
            end
            if (req_out) req_cnt++;
        end
        @(posedge clk);
        if (pe && !reset) begin
            pe_cnt++;
            for (int i = PL - 1; i > 0; i--) begin
                up_vld[i] = up_vld[i-1]; up_x[i] = up_x[i-1]; up_y[i] = up_y[i-1];
            end
            up_vld[0] = r_vld; up_x[0] = r_x; up_y[0] = r_y;
            if (m_h == 0 && m_v == 0) m_mode = mode;
            sb.push_back(model_pins(m_h, m_v, m_mode));
            if (m_h == HT - 1) begin
                m_h = 0;
                m_v = (m_v == VT - 1) ? 0 : m_v + 1;
            end else begin
                m_h++;
            end
            last_exp = sb.pop_front();
        end
        #1;
        got = pins_now();
        chk("pins", got, reset ? IDLE : last_exp);
        if (pe && !reset) begin
            if (!got.hs) begin
                if (prev_hs) begin
                    if (hs_fall_valid) chk("line_period", pe_cnt - hs_fall_last, HT);
                    hs_fall_last = pe_cnt; hs_fall_valid = 1;
                end
                hs_run++;
            end else begin
                if (hs_run > 0) chk("hsync_width", hs_run, HS);
                hs_run = 0;
            end
            if (!got.vs) vs_run++;
            else begin
                if (vs_run > 0) chk("vsync_width", vs_run, VS * HT);
                vs_run = 0;
            end
            prev_hs = got.hs; prev_vs = got.vs;
        end
    endtask

    task automatic run_to(input int x, input int y, input string name);
        int n = 0;
        while (!(m_h == x && m_v == y) && n < 2 * FRAME) begin
            tick(1'b1);
            n++;
        end
        if (!(m_h == x && m_v == y)) fail_timeout(name);
    endtask

    initial begin
        int cnt_bn, cnt_hs, cnt_vs, n;
        n_cmp = 0; n_bad = 0; pe_cnt = 0; fs_last = 0; hs_fall_last = 0;
        bar_bgr = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                    24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};
        vecs = '{
            '{2'd0,  5, 3, 24'hFF0305}, '{2'd0, 40, 3, 24'hFF0328},
            '{2'd1,  0, 1, 24'hFFFFFF}, '{2'd1,  7, 1, 24'hFFFFFF},
            '{2'd1,  8, 2, 24'h00FFFF}, '{2'd1, 16, 2, 24'hFFFF00},
            '{2'd1, 24, 2, 24'h00FF00}, '{2'd1, 32, 2, 24'hFF00FF},
            '{2'd1, 40, 2, 24'h0000FF}, '{2'd1, 48, 2, 24'hFF0000},
            '{2'd1, 56, 2, 24'h000000}, '{2'd1, 63, 2, 24'h000000},
            '{2'd3, 10, 4, 24'hFF040A}, '{2'd2, 10, 4, 24'h000000}
        };

        reset = 1'b1; pix_en = 1'b0; mode = 2'd0; color_in = '0;
        model_reset();
        #3;
        chk("reset_pins", pins_now(), IDLE);
        repeat (3) tick(1'b1);
        reset = 1'b0;

        // Two full frames, continuous pix_en: timing and pass-through.
        repeat (2 * FRAME + 20) tick(1'b1);

        // Vector table: exact latency from request to pins per mode.
        for (int i = 0; i < 14; i++) begin
            if (mode != vecs[i].mode) begin
                mode = vecs[i].mode;
                run_to(0, 0, "vec_frame");
            end
            run_to(vecs[i].x, vecs[i].y, "vec_pos");
            chk($sformatf("vec%0d_req", i), {req_out, req_x, req_y},
                {1'b1, 10'(vecs[i].x), 10'(vecs[i].y)});
            repeat (PL + 1) tick(1'b1);
            chk($sformatf("vec%0d_rgb", i), {blue, green, red}, vecs[i].exp_bgr);
        end

        // Mid-frame switch to forced blank waits for the next frame.
        mode = 2'd0;
        run_to(0, 0, "c_frame");
        tick(1'b1);
        run_to(0, 5, "c_row");
        mode = 2'd2;
        cnt_bn = 0; n = 0;
        do begin
            tick(1'b1);
            if (blank_n) cnt_bn++;
            n++;
        end while (!(m_h == 0 && m_v == 0) && n < 2 * FRAME);
        chk("blank_rest_of_frame", cnt_bn, 3 * HA);
        cnt_bn = 0; cnt_hs = 0; cnt_vs = 0;
        repeat (FRAME) begin
            tick(1'b1);
            if (blank_n) cnt_bn++;
            if (!hsync) cnt_hs++;
            if (!vsync) cnt_vs++;
        end
        chk("blank_forced_frame", cnt_bn, 0);
        chk("hsync_low_in_blank", cnt_hs, VT * HS);
        chk("vsync_low_in_blank", cnt_vs, VS * HT);

        // Colour bars under irregular pix_en.
        mode = 2'd1;
        repeat (2 * FRAME) tick($urandom_range(0, 3) != 0);

        // Freeze, resume, then asynchronous reset during hsync.
        mode = 2'd0;
        run_to(70, 2, "e_pos");
        repeat (3) tick(1'b0);
        tick(1'b1);
        chk("hsync_before_reset", hsync, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("reset_async", pins_now(), IDLE);
        model_reset();
        repeat (2) tick(1'b1);
        reset = 1'b0;
        repeat (3 * HT) tick(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_timing_painter.md
Name: vga_timing_painter

Overview:
- Parametrised VGA back-end: generates horizontal and vertical timing, issues pixel-coordinate requests upstream, and aligns returning colour with sync and blank.
- Drives DAC-style RGB, hsync/vsync, sync_n and blank_n.
- Sits between the frame-buffer/colour-generation logic and the video DAC pins.
- Adds built-in test-pattern and forced-blank modes, selectable per frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- COLOR_W, 8, bits per colour channel
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level (0 = active-low)
- PIPE_LAT, 2, pixel-clock cycles from req_out to valid color_in (range 0..7)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel-clock enable; all state advances only when high
- mode  in  2  0 = pass-through, 1 = colour bars, 2 = forced blank, 3 = pass-through
- color_in  in  3*COLOR_W  {blue, green, red}; blue is the MSB field
- req_out  out  1  pixel request; high for visible coordinates
- req_x  out  10  column of the current request
- req_y  out  10  row of the current request
- frame_start  out  1  one-cycle pulse at h=0, v=0 (pix_en-qualified)
- red  out  COLOR_W  red channel
- green  out  COLOR_W  green channel
- blue  out  COLOR_W  blue channel
- hsync  out  1  horizontal sync, polarity set by HS_POL
- vsync  out  1  vertical sync, polarity set by VS_POL
- sync_n  out  1  composite sync, low while hsync or vsync is asserted
- blank_n  out  1  low outside the visible region

Behaviour:
- Timing totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- h counter runs 0..H_TOTAL-1 and wraps to 0. v increments only on an h wrap, and wraps to 0 at V_TOTAL-1 when h also wraps.
- Phase FSM per axis: ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE.
  - Each transition occurs when the axis counter equals that phase's last index.
  - Horizontal phase boundaries at defaults: 639, 655, 751, 799.
- Stage 0 (combinational from counters):
  - req_out = hACTIVE & vACTIVE.
  - req_x = h and req_y = v when req_out is high, else 0.
  - frame_start = (h==0 & v==0 & pix_en).
- Alignment pipeline:
  - A PIPE_LAT-deep shift register (enabled by pix_en) carries visible, hs_act, vs_act and the bar index (h / (H_ACTIVE/8)).
  - color_in is sampled when the delayed control emerges.
- Output register (stage PIPE_LAT+1): total latency from counter value to pins is PIPE_LAT+1 pix_en cycles. Sync and colour stay aligned.
- Colour select at the output register:
  - Not visible: 0.
  - mode 0 or 3: color_in.
  - mode 1: bar LUT in order white, yellow, cyan, green, magenta, red, blue, black. Channels are all-ones or all-zeros.
  - mode 2: 0, with blank_n forced low; sync still runs.
- Mode is latched only on the frame_start cycle.
  - A mid-frame change has no effect until the next frame.
  - Reset value of the latched mode is 0.
- pix_en low: counters, phases, pipeline and outputs all hold. No pulse is lost or duplicated.
- sync_n = ~(hs_act | vs_act). blank_n = delayed visible & (latched mode != 2).
- Reset (async assert, release synchronous to clk):
  - h = v = 0, pipeline cleared.
  - RGB = 0, blank_n = 0, sync_n = 1.
  - hsync = ~HS_POL and vsync = ~VS_POL (deasserted levels).
  - The first frame_start pulses on the first pix_en cycle after release.
- Reset mid-frame aborts the frame immediately. No partial sync pulse is extended.
- Elaboration assertions: H_ACTIVE divisible by 8; H_TOTAL and V_TOTAL ≤ 1024.

Decomposition:
- Package vga_pkg holds:
  - mode_e (PASS, BARS, BLANK, PASS2)
  - phase_e (ACTIVE, FRONT, SYNC, BACK)
  - bar colour LUT as a function of bar index and COLOR_W
- Sub-module vga_axis_counter (parameters ACTIVE, FP, SYNC, BP):
  - Inputs: clk, reset, inc, and wrap-enable.
  - Outputs: count, phase, last.
  - Instantiated twice: horizontal inc = pix_en; vertical inc = pix_en & h_last.

Test Plan:
- Reset release, defaults, pix_en = 1: hsync falls low at h = 656+3 cycles after line start, stays low 96 cycles, and the line period is exactly 800 cycles.
- Full frame: vsync low for exactly 2×800 cycles. frame_start pulses every 420000 cycles, with 307200 req_out cycles per frame.
- Mode 0 with color_in = {blue, green, red} = 0xFF0000 and req_x echo: blue = 0xFF and red = 0 appear exactly 3 cycles after req_out. blank_n is low for h ≥ 640 (delayed by 3).
- Mode 1: pixels 0..79 read 0xFFFFFF, pixels 80..159 read yellow (red = green = 0xFF, blue = 0), and pixels 560..639 read 0. color_in is ignored.
- Mode changed 0→2 at v = 100: output stays pass-through until the next frame_start, then blank_n = 0 all frame while hsync/vsync keep their timing.
- pix_en toggling 1-0-1 with reset asserted at h = 700: counters freeze while pix_en = 0. On reset, outputs go immediately to RGB = 0, sync deasserted, blank_n = 0, and restart at h = 0.
